// File: rtl/mult32_seq_ctrl_pkg.sv
// Shared MIPS multiply definitions: FSM encodings, operand width
// and the main-control decode constants for multu.
package mult32_seq_ctrl_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/mult32_seq_ctrl_adder.sv
// Combinational adder with carry-out used for the
// accumulate step of the shift-add multiplier.
module adder_32bit_cout #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mult32_seq_ctrl.sv
// Sequential unsigned shift-add multiplier for multu with a
// start/busy/done handshake; product is presented as {HI, LO}.
module mult32_seq_ctrl
  import mult32_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH:0]   step;

  adder_32bit_cout #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i    (acc_q[2*WIDTH-1:WIDTH]),
    .b_i    (mcand_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    step = acc_q;
    if (acc_q[0]) begin
      step = {cout, sum, acc_q[WIDTH-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CALC: begin
        acc_d = step >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      // IDLE, DONE and the unused 2'b11 all behave as IDLE
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          mcand_d = a;
          acc_d   = {{(WIDTH+1){1'b0}}, b};
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs trail the state by one cycle so done and product
  // stay aligned even when a new start reloads acc in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      prod_q <= '0;
    end else begin
      busy_q <= (state_q == ST_CALC);
      done_q <= (state_q == ST_DONE);
      prod_q <= acc_q[2*WIDTH-1:0];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed bench for mult32_seq_ctrl with a product
// scoreboard and latency/handshake checks.
module tb_mult32_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic [63:0] sb[$];
  int          n_pass;
  int          n_total;

  mult32_seq_ctrl #(
    .WIDTH (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue(input logic [31:0] av,
                       input logic [31:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    sb.push_back({32'd0, av} * {32'd0, bv});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input  int lat0,
                           output int lat,
                           output int busy_n,
                           output int overlap);
    lat     = lat0;
    busy_n  = 0;
    overlap = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) break;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] exp;
    exp = 64'hBAD0_BAD0_BAD0_BAD0;
    if (sb.size() > 0) exp = sb.pop_front();
    check(tag, product, exp);
  endtask

  task automatic op_check(input string tag,
                          input logic [31:0] av,
                          input logic [31:0] bv);
    int lat, bn, ov;
    logic [63:0] held;
    issue(av, bv);
    wait_done(0, lat, bn, ov);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_busy"}, 64'(bn), 64'd32);
    check({tag, "_ovl"}, 64'(ov), 64'd0);
    pop_check({tag, "_prod"});
    held = product;
    @(posedge clk);
    #1;
    check({tag, "_dpulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, product, held);
  endtask

  initial begin
    int lat, bn, ov;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("m3x5", 32'd3, 32'd5);
    check("m3x5_const", 64'h0000_0000_0000_000F, 64'd15);
    op_check("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_check("mbx0", 32'h1234_5678, 32'h0);
    op_check("m0xb", 32'h0, 32'hDEAD_BEEF);

    // start during CALC must be ignored
    issue(32'h0001_1111, 32'h0000_0010);
    repeat (10) @(posedge clk);
    #1;
    a     = 32'd99;
    b     = 32'd77;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(11, lat, bn, ov);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_ovl", 64'(ov), 64'd0);
    pop_check("ign_prod");
    @(posedge clk);
    #1;
    check("ign_nodone", 64'(done), 64'd0);

    // reset in the middle of CALC
    issue(32'h0000_ABCD, 32'h0000_1234);
    void'(sb.pop_back());
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_prod", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op_check("m7x9", 32'd7, 32'd9);

    // back-to-back: start held through the DONE cycle
    @(negedge clk);
    a     = 32'd2;
    b     = 32'd2;
    start = 1'b1;
    sb.push_back(64'd4);
    @(posedge clk);
    #1;
    a = 32'd6;
    b = 32'd7;
    sb.push_back(64'd42);
    wait_done(0, lat, bn, ov);
    start = 1'b0;
    check("b2b1_lat", 64'(lat), 64'd33);
    check("b2b1_ovl", 64'(ov), 64'd0);
    pop_check("b2b1_prod");
    wait_done(0, lat, bn, ov);
    check("b2b2_lat", 64'(lat), 64'd33);
    check("b2b2_busy", 64'(bn), 64'd32);
    check("b2b2_ovl", 64'(ov), 64'd0);
    pop_check("b2b2_prod");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
